// File: rtl/regfile_wb_param.sv
// rtl/regfile_wb_param.sv - RV32 integer register file with sequenced writeback commit and flush pulse
// Write path: IDLE -> HOLD (WB_DELAY cycles) -> WRITE (commit) -> FLUSH (one-cycle pulse) -> IDLE.
module regfile_wb_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int WB_DELAY = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wb_valid,
  output logic                   o_wb_ready,
  input  logic [AW-1:0]          i_wb_rd,
  input  logic [XLEN-1:0]        i_wb_data,
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  input  logic [AW-1:0]          i_dbg_addr,
  output logic [XLEN-1:0]        o_dbg_data,
  output logic                   o_busy,
  output logic                   o_flush
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WRITE, S_FLUSH} state_t;

  localparam logic [3:0]  CNT_INIT = (WB_DELAY > 0) ? 4'(WB_DELAY - 1) : 4'd0;
  localparam logic [31:0] NREGS_U  = NREGS;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_data;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_accept;
  logic            w_commit;
  logic            w_pending;

  // Addresses past the end of a non-power-of-2 file read as 0 and never write.
  function automatic logic f_in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS_U;
  endfunction

  always_comb begin
    w_next     = r_state;
    o_wb_ready = 1'b0;
    o_busy     = 1'b0;
    o_flush    = 1'b0;
    w_accept   = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_wb_ready = 1'b1;
        if (i_wb_valid) begin
          w_accept = 1'b1;
          w_next   = (WB_DELAY == 0) ? S_WRITE : S_HOLD;
        end
      end
      S_HOLD: begin
        o_busy = 1'b1;
        if (r_cnt == 4'd0) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_busy   = 1'b1;
        w_commit = 1'b1;
        w_next   = S_FLUSH;
      end
      S_FLUSH: begin
        o_busy  = 1'b1;
        o_flush = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_data  <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rd   <= i_wb_rd;
        r_data <= i_wb_data;
        r_cnt  <= CNT_INIT;
      end else if (r_state == S_HOLD && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_commit && f_in_range(r_rd) && !(ZERO_REG != 0 && r_rd == '0)) begin
      r_regs[r_rd] <= r_data;
    end
  end

  assign w_pending  = (BYPASS != 0) && (r_state == S_HOLD || r_state == S_WRITE);
  assign o_dbg_data = f_in_range(i_dbg_addr) ? r_regs[i_dbg_addr] : '0;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_zero;
    logic          w_hit;
    assign w_addr = i_rd_addr[k*AW +: AW];
    assign w_zero = !f_in_range(w_addr) || (ZERO_REG != 0 && w_addr == '0);
    assign w_hit  = w_pending && (w_addr == r_rd);
    assign o_rd_data[k*XLEN +: XLEN] = w_zero ? '0 : (w_hit ? r_data : r_regs[w_addr]);
  end

endmodule

// File: tb/tb_regfile_wb_param.sv
// tb/tb_regfile_wb_param.sv - directed bench for regfile_wb_param (bypass and no-bypass instances)
module tb_regfile_wb_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [9:0]  rd_addr;
  logic [4:0]  dbg_addr;

  logic        rdy_b, busy_b, flush_b;
  logic [63:0] rdd_b;
  logic [31:0] dbg_b;
  logic        rdy_n, busy_n, flush_n;
  logic [63:0] rdd_n;
  logic [31:0] dbg_n;

  int n_vec = 0;
  int n_err = 0;
  int flush_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (flush_b) flush_cnt++;

  regfile_wb_param #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .i_wb_valid(wb_valid), .o_wb_ready(rdy_b), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .i_rd_addr(rd_addr), .o_rd_data(rdd_b), .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_b), .o_busy(busy_b), .o_flush(flush_b)
  );

  regfile_wb_param #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .i_wb_valid(wb_valid), .o_wb_ready(rdy_n), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .i_rd_addr(rd_addr), .o_rd_data(rdd_n), .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_n), .o_busy(busy_n), .o_flush(flush_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output int cyc);
    cyc = 0;
    while (!rdy_b && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    int c;
    wait_ready(20, c);
    chk("wr_pre_ready", {31'd0, rdy_b}, 32'd1);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
    wait_ready(20, c);
    chk("wr_latency", c, 32'd3);
  endtask

  initial begin
    int fc;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    rd_addr  = '0;
    dbg_addr = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // reset state
    chk("rst_ready", {31'd0, rdy_b}, 32'd1);
    chk("rst_flush", {31'd0, flush_b}, 32'd0);
    chk("rst_busy", {31'd0, busy_b}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("rst_dbg%0d", i), dbg_b, 32'd0);
    end

    // commit timing and bypass
    write_reg(5'd5, 32'h1111_1111);
    rd_addr  = {5'd5, 5'd5};
    dbg_addr = 5'd5;
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hDEAD_BEEF;
    tick();
    wb_valid = 1'b0;
    chk("hold_busy", {31'd0, busy_b}, 32'd1);
    chk("hold_ready", {31'd0, rdy_b}, 32'd0);
    chk("hold_flush", {31'd0, flush_b}, 32'd0);
    chk("hold_byp_p1", rdd_b[63:32], 32'hDEAD_BEEF);
    chk("hold_byp_p0", rdd_b[31:0], 32'hDEAD_BEEF);
    chk("hold_nobyp_p1", rdd_n[63:32], 32'h1111_1111);
    chk("hold_dbg", dbg_b, 32'h1111_1111);
    tick();
    chk("write_byp_p1", rdd_b[63:32], 32'hDEAD_BEEF);
    chk("write_nobyp_p1", rdd_n[63:32], 32'h1111_1111);
    chk("write_dbg", dbg_b, 32'h1111_1111);
    chk("write_flush", {31'd0, flush_b}, 32'd0);
    tick();
    chk("flush_pulse", {31'd0, flush_b}, 32'd1);
    chk("flush_pulse_nb", {31'd0, flush_n}, 32'd1);
    chk("flush_ready", {31'd0, rdy_b}, 32'd0);
    chk("flush_dbg", dbg_b, 32'hDEAD_BEEF);
    chk("flush_nobyp_p1", rdd_n[63:32], 32'hDEAD_BEEF);
    tick();
    chk("idle_flush", {31'd0, flush_b}, 32'd0);
    chk("idle_ready", {31'd0, rdy_b}, 32'd1);
    chk("idle_busy", {31'd0, busy_b}, 32'd0);
    chk("idle_p0", rdd_b[31:0], 32'hDEAD_BEEF);

    // rd=0 write: flush still runs, reg0 stays 0
    fc = flush_cnt;
    rd_addr  = {5'd0, 5'd0};
    dbg_addr = 5'd0;
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h0000_1234;
    tick();
    wb_valid = 1'b0;
    chk("z_hold_p0", rdd_b[31:0], 32'd0);
    chk("z_hold_p1", rdd_b[63:32], 32'd0);
    begin
      int c;
      wait_ready(20, c);
      chk("z_latency", c, 32'd3);
    end
    chk("z_flush_cnt", flush_cnt - fc, 32'd1);
    chk("z_p0", rdd_b[31:0], 32'd0);
    chk("z_nb_p1", rdd_n[63:32], 32'd0);
    chk("z_dbg", dbg_b, 32'd0);

    // valid held high during busy: only first commits; next accepted once ready
    dbg_addr = 5'd7;
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 32'hAAAA_0001;
    tick();
    wb_rd    = 5'd9;
    wb_data  = 32'hBBBB_0002;
    tick();
    wb_data  = 32'hCCCC_0003;
    tick();
    chk("bb_flush", {31'd0, flush_b}, 32'd1);
    chk("bb_dbg7", dbg_b, 32'hAAAA_0001);
    wb_rd    = 5'd7;
    wb_data  = 32'hDDDD_0004;
    dbg_addr = 5'd9;
    #1;
    chk("bb_dbg9", dbg_b, 32'd0);
    tick();
    chk("bb_ready", {31'd0, rdy_b}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("bb_accept2", {31'd0, busy_b}, 32'd1);
    begin
      int c;
      wait_ready(20, c);
      chk("bb_latency2", c, 32'd3);
    end
    dbg_addr = 5'd7;
    #1;
    chk("bb_dbg7_2", dbg_b, 32'hDDDD_0004);
    dbg_addr = 5'd9;
    #1;
    chk("bb_dbg9_2", dbg_b, 32'd0);

    // reset during HOLD drops the pending write
    dbg_addr = 5'd3;
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'h0000_0055;
    tick();
    wb_valid = 1'b0;
    chk("rh_busy", {31'd0, busy_b}, 32'd1);
    fc = flush_cnt;
    rst = 1'b0;
    #1;
    chk("rh_busy0", {31'd0, busy_b}, 32'd0);
    chk("rh_ready", {31'd0, rdy_b}, 32'd1);
    chk("rh_flush", {31'd0, flush_b}, 32'd0);
    chk("rh_dbg3", dbg_b, 32'd0);
    dbg_addr = 5'd5;
    #1;
    chk("rh_dbg5", dbg_b, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("rh_no_flush", flush_cnt - fc, 32'd0);
    chk("rh_ready2", {31'd0, rdy_b}, 32'd1);
    dbg_addr = 5'd3;
    #1;
    chk("rh_dbg3_2", dbg_b, 32'd0);
    write_reg(5'd3, 32'h0000_0077);
    chk("post_dbg3", dbg_b, 32'h0000_0077);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
